// File: rtl/sort_pkg.sv
// sort_pkg: shared types and defaults for the pixel sorting engine.
//   state_t  : engine phase, LOAD -> SORT -> DRAIN -> LOAD
//   DEF_*    : default key width, tag width and frame depth
//   slot_t   : one stored word {key, tag} at the default widths
package sort_pkg;
   typedef enum logic [1:0] {LOAD, SORT, DRAIN} state_t;
   localparam int DEF_WIDTH = 16;
   localparam int DEF_TAG_W = 8;
   localparam int DEF_DEPTH = 8;
   typedef struct packed {
      logic [DEF_WIDTH-1:0] key;
      logic [DEF_TAG_W-1:0] tag;
   } slot_t;
endpackage

// File: rtl/compare_swap.sv
// compare_swap: combinational compare-and-swap cell on {key, tag} words.
//   a, b    : words entering the cell, a sits at the lower slot index
//   desc    : 0 orders ascending, 1 orders descending
//   lo_out  : word leaving toward the lower slot index
//   hi_out  : word leaving toward the higher slot index
// Only the key is compared; equal keys keep their positions so sorting stays stable.
module compare_swap import sort_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W
) (
   input  logic [WIDTH+TAG_W-1:0] a,
   input  logic [WIDTH+TAG_W-1:0] b,
   input  logic                   desc,
   output logic [WIDTH+TAG_W-1:0] lo_out,
   output logic [WIDTH+TAG_W-1:0] hi_out
);
   logic [WIDTH-1:0] ka, kb;
   logic swap;
   assign ka = a[WIDTH+TAG_W-1:TAG_W];
   assign kb = b[WIDTH+TAG_W-1:TAG_W];
   assign swap = desc ? (ka < kb) : (ka > kb);
   assign lo_out = swap ? b : a;
   assign hi_out = swap ? a : b;
endmodule

// File: rtl/pixel_sort_engine.sv
// pixel_sort_engine: frame sorter built on an odd-even transposition network.
//   clk, rst                     : clock, asynchronous active-high reset
//   in_valid/in_ready            : input handshake, ready only while loading
//   in_key, in_tag, in_desc      : input word; direction taken from the first word
//   out_valid/out_ready          : output handshake, valid only while draining
//   out_key, out_tag, out_last   : sorted word, last flags the final word of a frame
//   busy                         : high while sorting or draining
module pixel_sort_engine import sort_pkg::*; #(
   parameter int WIDTH = DEF_WIDTH,
   parameter int TAG_W = DEF_TAG_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_key,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             in_desc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_key,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_last,
   output logic             busy
);
   localparam int SW = WIDTH + TAG_W;
   localparam int IW = $clog2(DEPTH);
   localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

   state_t state;
   logic [IW-1:0] wr_idx, phase, rd_idx;
   logic desc;
   logic [DEPTH-1:0][SW-1:0] slot, net;
   logic [DEPTH-2:0][SW-1:0] lo, hi;
   logic [SW-1:0] rd_word;

   genvar i;
   for (i = 0; i < DEPTH - 1; i++) begin : g_cs
      compare_swap #(.WIDTH(WIDTH), .TAG_W(TAG_W)) u_cs (
         .a(slot[i]), .b(slot[i+1]), .desc(desc), .lo_out(lo[i]), .hi_out(hi[i])
      );
   end

   // Cell j sits between slots j and j+1; it is active when its parity matches the phase.
   always_comb begin
      net = slot;
      for (int j = 0; j < DEPTH - 1; j++)
         if (j[0] == phase[0]) begin
            net[j]   = lo[j];
            net[j+1] = hi[j];
         end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= LOAD;
         wr_idx <= '0;
         phase  <= '0;
         rd_idx <= '0;
         desc   <= 1'b0;
         slot   <= '0;
      end else begin
         case (state)
            LOAD: if (in_valid) begin
               slot[wr_idx] <= {in_key, in_tag};
               if (wr_idx == '0) desc <= in_desc;
               if (wr_idx == LAST) begin
                  state  <= SORT;
                  wr_idx <= '0;
                  phase  <= '0;
               end else wr_idx <= wr_idx + 1'b1;
            end
            SORT: begin
               slot <= net;
               if (phase == LAST) begin
                  state  <= DRAIN;
                  rd_idx <= '0;
               end else phase <= phase + 1'b1;
            end
            DRAIN: if (out_ready) begin
               if (rd_idx == LAST) begin
                  state  <= LOAD;
                  rd_idx <= '0;
               end else rd_idx <= rd_idx + 1'b1;
            end
            default: state <= LOAD;
         endcase
      end
   end

   assign rd_word   = slot[rd_idx];
   assign in_ready  = state == LOAD;
   assign out_valid = state == DRAIN;
   assign busy      = state != LOAD;
   assign out_key   = out_valid ? rd_word[SW-1:TAG_W] : '0;
   assign out_tag   = out_valid ? rd_word[TAG_W-1:0] : '0;
   assign out_last  = out_valid && rd_idx == LAST;
endmodule

// File: tb/tb_pixel_sort_engine.sv
// tb_pixel_sort_engine: randomized and directed checks against a stable-sort reference.
module tb_pixel_sort_engine;
   localparam int W = 16, T = 8, D = 8;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;

   logic in_valid = 0, in_ready, in_desc = 0, out_valid, out_ready = 0, out_last, busy;
   logic [W-1:0] in_key = 0, out_key;
   logic [T-1:0] in_tag = 0, out_tag;

   logic s_in_valid = 0, s_in_ready, s_in_desc = 0, s_out_valid, s_out_ready = 0, s_out_last, s_busy;
   logic s_in_key = 0, s_out_key;
   logic [T-1:0] s_in_tag = 0, s_out_tag;

   pixel_sort_engine #(.WIDTH(W), .TAG_W(T), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
      .in_tag(in_tag), .in_desc(in_desc), .out_valid(out_valid), .out_ready(out_ready),
      .out_key(out_key), .out_tag(out_tag), .out_last(out_last), .busy(busy));

   pixel_sort_engine #(.WIDTH(1), .TAG_W(T), .DEPTH(2)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_key(s_in_key),
      .in_tag(s_in_tag), .in_desc(s_in_desc), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .out_key(s_out_key), .out_tag(s_out_tag), .out_last(s_out_last), .busy(s_busy));

   int n_chk = 0, n_err = 0;
   logic [W-1:0] fk [D], ek [D];
   logic [T-1:0] ft [D], et [D];
   logic fdesc;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: stable insertion sort; a word moves ahead only on a strict key order.
   function automatic void model();
      for (int i = 0; i < D; i++) begin
         ek[i] = fk[i];
         et[i] = ft[i];
      end
      for (int i = 1; i < D; i++) begin
         logic [W-1:0] k = ek[i];
         logic [T-1:0] t = et[i];
         int j = i;
         while (j > 0 && (fdesc ? k > ek[j-1] : k < ek[j-1])) begin
            ek[j] = ek[j-1];
            et[j] = et[j-1];
            j--;
         end
         ek[j] = k;
         et[j] = t;
      end
   endfunction

   task automatic send_frame();
      for (int i = 0; i < D; i++) begin
         @(negedge clk);
         chk("in_ready_load", in_ready, 1);
         in_valid = 1;
         in_key = fk[i];
         in_tag = ft[i];
         in_desc = i == 0 ? fdesc : ~fdesc;
      end
      @(posedge clk);
   endtask

   // Called right after the edge that accepted the last word; in_valid stays high as junk.
   task automatic wait_sort();
      for (int n = 0; n < D; n++) begin
         @(negedge clk);
         in_key = W'($urandom);
         chk("sort_out_valid", out_valid, 0);
         chk("sort_in_ready", in_ready, 0);
         chk("sort_busy", busy, 1);
      end
      @(negedge clk);
      chk("lat_out_valid", out_valid, 1);
      chk("lat_first_key", out_key, ek[0]);
   endtask

   task automatic drain(input int mode);
      int idx = 0;
      for (int c = 0; c < 200 && idx < D; c++) begin
         @(negedge clk);
         chk("drain_valid", out_valid, 1);
         chk("drain_busy", busy, 1);
         chk("drain_key", out_key, ek[idx]);
         chk("drain_tag", out_tag, et[idx]);
         chk("drain_last", out_last, idx == D - 1);
         in_valid = idx < D - 1;
         in_key = W'($urandom);
         out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 3 == 0) : 1'($urandom);
         @(posedge clk);
         if (out_ready) idx++;
      end
      chk("drain_count", idx, D);
      @(negedge clk);
      out_ready = 0;
      in_valid = 0;
      chk("end_in_ready", in_ready, 1);
      chk("end_busy", busy, 0);
      chk("end_out_valid", out_valid, 0);
   endtask

   task automatic run_frame(input int mode);
      model();
      send_frame();
      wait_sort();
      drain(mode);
   endtask

   task automatic small_run(input logic k0, input logic k1, input logic d, input logic x0,
                            input logic x1, input logic [T-1:0] t0, input logic [T-1:0] t1);
      int c = 0;
      @(negedge clk);
      s_in_valid = 1; s_in_key = k0; s_in_tag = 0; s_in_desc = d;
      @(negedge clk);
      s_in_key = k1; s_in_tag = 1; s_in_desc = ~d;
      @(negedge clk);
      s_in_valid = 0;
      while (!s_out_valid && c < 10) begin
         @(negedge clk);
         c++;
      end
      chk("s_valid", s_out_valid, 1);
      chk("s_key0", s_out_key, x0);
      chk("s_tag0", s_out_tag, t0);
      chk("s_last0", s_out_last, 0);
      s_out_ready = 1;
      @(negedge clk);
      chk("s_key1", s_out_key, x1);
      chk("s_tag1", s_out_tag, t1);
      chk("s_last1", s_out_last, 1);
      @(negedge clk);
      s_out_ready = 0;
      chk("s_in_ready", s_in_ready, 1);
   endtask

   initial begin
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_key", out_key, 0);
      chk("rst_out_tag", out_tag, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_busy", busy, 0);
      @(negedge clk);
      rst = 0;

      begin
         logic [W-1:0] k0 [D] = '{16'd9, 16'd3, 16'd7, 16'd0, 16'hFFFF, 16'd3, 16'd1, 16'd8};
         for (int i = 0; i < D; i++) begin
            fk[i] = k0[i];
            ft[i] = T'(i);
         end
      end
      fdesc = 0;
      run_frame(0);
      fdesc = 1;
      run_frame(1);

      for (int f = 0; f < 6; f++) begin
         fdesc = 1'($urandom);
         for (int i = 0; i < D; i++) begin
            fk[i] = f[0] ? W'($urandom_range(0, 3)) : W'($urandom);
            ft[i] = T'($urandom);
         end
         run_frame(f % 3);
      end

      for (int i = 0; i < D; i++) begin
         fk[i] = W'($urandom);
         ft[i] = T'(i);
      end
      fdesc = 0;
      send_frame();
      for (int n = 0; n < 4; n++) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("mid_rst_out_valid", out_valid, 0);
      chk("mid_rst_in_ready", in_ready, 1);
      chk("mid_rst_busy", busy, 0);
      in_valid = 0;
      @(negedge clk);
      rst = 0;
      begin
         logic [W-1:0] k1 [D] = '{16'd4, 16'd2, 16'd6, 16'd1, 16'd5, 16'd3, 16'd0, 16'd7};
         for (int i = 0; i < D; i++) begin
            fk[i] = k1[i];
            ft[i] = T'(8'h10 + i);
         end
      end
      fdesc = 0;
      run_frame(2);

      small_run(1, 0, 0, 0, 1, 1, 0);
      small_run(0, 0, 0, 0, 0, 0, 1);
      small_run(0, 1, 1, 1, 0, 1, 0);
      small_run(1, 1, 1, 1, 1, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
